// File: rtl/arch_defs_pkg.sv
// Shared architecture constants and types for the memory subsystem.
package arch_defs_pkg;

  localparam int ADDR_WIDTH     = 16;
  localparam int DATA_WIDTH     = 8;
  localparam int MEM_ARB_WAIT_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } mem_arb_state_t;

  // Winning port for one IDLE cycle; only meaningful when at least one req is high.
  function automatic logic mem_arb_winner(input logic req0,
                                          input logic req1,
                                          input logic last_grant,
                                          input logic round_robin);
    if (req0 && req1) begin
      return round_robin ? ~last_grant : 1'b0;
    end
    return ~req0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-port RAM bus arbiter (port 0 = CPU, port 1 = loader) with programmable wait states.
// Define MEM_ARB_ROUND_ROBIN_EN to replace fixed port-0 priority with round-robin tie breaking.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = arch_defs_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = arch_defs_pkg::DATA_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  busy,
  output logic                  grant_id
);
  import arch_defs_pkg::*;

  localparam logic [MEM_ARB_WAIT_W-1:0] WAIT_LOAD = MEM_ARB_WAIT_W'(WAIT_STATES);

  mem_arb_state_t            state;
  mem_arb_state_t            state_next;
  logic [MEM_ARB_WAIT_W-1:0] wait_cnt;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata0_q;
  logic [DATA_WIDTH-1:0]     rdata1_q;
  logic                      we_q;
  logic                      grant_q;
  logic                      any_req;
  logic                      winner;

  assign any_req = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Reset to 1 so that port 0 wins the first tie after reset.
  logic last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == ARB_IDLE && any_req) begin
      last_grant <= winner;
    end
  end

  assign winner = mem_arb_winner(req0, req1, last_grant, 1'b1);
`else
  assign winner = mem_arb_winner(req0, req1, 1'b0, 1'b0);
`endif

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (any_req) state_next = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        if (wait_cnt == '0) state_next = ARB_DONE;
      end
      ARB_DONE: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Request fields are latched at the grant edge, so later input changes cannot disturb the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      grant_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q  <= winner;
            we_q     <= winner ? we1 : we0;
            addr_q   <= winner ? addr1 : addr0;
            wdata_q  <= winner ? wdata1 : wdata0;
            wait_cnt <= WAIT_LOAD;
          end
        end
        ARB_ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (!we_q) begin
            if (grant_q) rdata1_q <= mem_data_in;
            else         rdata0_q <= mem_data_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes and acks decode straight from the state so an async reset clears them at once.
  assign mem_read     = (state == ARB_ACCESS) && !we_q;
  assign mem_write    = (state == ARB_ACCESS) &&  we_q;
  assign ack0         = (state == ARB_DONE) && !grant_q;
  assign ack1         = (state == ARB_DONE) &&  grant_q;
  assign busy         = (state != ARB_IDLE);
  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;
  assign grant_id     = grant_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single RAM bus between two requesters: port 0 is the CPU memory interface, port 1 is the debug/UART program loader.
- Each requester uses a req/ack handshake. The block drives the RAM-side address, read strobe, write strobe and write data, and returns read data to the winning requester.
- Inserts programmable wait states so slower RAM/ROM macros can be used. Sits between the CPU/loader and the top-level memory map.

Parameters:
- ADDR_WIDTH, default ADDR_WIDTH from arch_defs_pkg (16): address width.
- DATA_WIDTH, default DATA_WIDTH from arch_defs_pkg (8): data width.
- WAIT_STATES, default 1: extra cycles the RAM strobes are held; legal range 0..7.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  access request from requester 0 / 1.
- we0, we1  in  1 each  1 = write, 0 = read; sampled with req.
- addr0, addr1  in  ADDR_WIDTH each  access address.
- wdata0, wdata1  in  DATA_WIDTH each  write data.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- rdata0, rdata1  out  DATA_WIDTH each  read data; valid while the matching ack is high and held until that port's next ack.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_data_out  out  DATA_WIDTH  RAM write data.
- mem_data_in  in  DATA_WIDTH  RAM read data.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  port owning the current or last access.

Behaviour:
- **Reset values:** state IDLE; ack0 = ack1 = 0; mem_read = mem_write = 0; mem_address = 0; mem_data_out = 0; rdata0 = rdata1 = 0; grant_id = 0; busy = 0; wait counter = 0.
- **FSM states:**
  - IDLE: arbitrates. If any req is high, latch the winner's addr/we/wdata into internal registers, set grant_id, load the wait counter with WAIT_STATES, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_address and mem_data_out come from the latched registers. mem_read = !we_latched, mem_write = we_latched. Exactly one strobe is high. If the counter is nonzero, decrement it and stay. If it is zero, capture mem_data_in into rdata[grant_id] (reads only) and go to DONE.
  - DONE: strobes low; ack[grant_id] = 1 for this single cycle; next state is always IDLE.
- **Latency:** req is seen high before edge 0. ACCESS occupies cycles 1 .. WAIT_STATES+1, DONE is cycle WAIT_STATES+2. With the default, ack is high in cycle 3. Minimum spacing between two accesses is WAIT_STATES+3 cycles.
- **Handshake:**
  - Requester holds req, we, addr and wdata stable until it samples ack.
  - A requester that keeps req high after ack is issuing a new access; it updates its fields during the IDLE cycle.
  - Changes to a granted requester's inputs after the IDLE edge are ignored because the fields are latched.
  - If req drops mid-access, the access still completes and ack still pulses.
- **Arbitration (macro absent):** fixed priority, port 0 wins ties. Port 1 is served only in an IDLE cycle where req0 = 0.
- **Outputs:** mem_address and mem_data_out hold their last value outside ACCESS. ack0 and ack1 are never high together.
- **Reset mid-access:** async reset drops the strobes immediately, no ack is issued, and the access is discarded. Requesters must re-request after reset.
- **WAIT_STATES = 0:** ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On a tie, the port not equal to the last grant_id wins. After reset, last grant is treated as 1, so port 0 wins the first tie.
- Undefined: fixed priority as described under Behaviour. Single-requester behaviour is identical in both builds.

Decomposition:
- arch_defs_pkg gains:
  - mem_arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_DONE}.
  - MEM_ARB_WAIT_W = 3, the width of the wait counter.
- No sub-module. Arbitration is a small combinational block inside the module, with the winner select switched by the macro.

Test Plan:
- **Read, port 0:** req0 = 1, we0 = 0, addr0 = 0x0010, RAM[0x0010] = 0xA5, WAIT_STATES = 1 → mem_read high for cycles 1–2 with mem_address = 0x0010; ack0 pulses in cycle 3 with rdata0 = 0xA5; ack1 stays 0.
- **Write, port 1:** req1 = 1, we1 = 1, addr1 = 0x0200, wdata1 = 0x3C → mem_write high for 2 cycles, mem_data_out = 0x3C; ack1 pulses once; a later port-0 read of 0x0200 returns 0x3C.
- **Simultaneous requests, both held 4 accesses:**
  - Fixed priority: grant order 0,0,0,0 with port 1 starved until req0 drops.
  - With MEM_ARB_ROUND_ROBIN_EN: grant order 0,1,0,1.
- **Reset mid-access:** assert reset during the 2nd ACCESS cycle → mem_read = 0 in the same cycle, no ack, busy = 0; after release a new req0 completes normally.
- **WAIT_STATES = 0:** back-to-back reads of 0x0000 then 0x0001 → acks 3 cycles apart; each strobe is high for exactly 1 cycle.
- **Input change after grant:** change addr0 from 0x0010 to 0x0020 one cycle after grant → mem_address stays 0x0010 for the whole access.
